// File: rtl/window_pkg.sv
// Shared types and constants for the 3x3 window generator.
// Pixel layout is RGB888: R[23:16], G[15:8], B[7:0].
package window_pkg;

  localparam int PIXEL_W        = 24;
  localparam int CH_W           = 8;
  localparam int DEF_IMG_WIDTH  = 512;
  localparam int DEF_IMG_HEIGHT = 512;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef struct packed {
    pixel_t top;
    pixel_t mid;
    pixel_t bot;
  } wcol_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM
  } state_t;

  function automatic pixel_t pack_rgb(
    input logic [CH_W-1:0] r,
    input logic [CH_W-1:0] g,
    input logic [CH_W-1:0] b
  );
    return {r, g, b};
  endfunction

endpackage

// File: rtl/line_buffer.sv
// Simple dual-port line store with registered read.
// Contents are never reset; readers only consume written entries.
module line_buffer
  import window_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_WIDTH,
  parameter int WIDTH = PIXEL_W,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/window_generator_3x3.sv
// Raster-scan 3x3 window generator, 2-cycle latency.
// Define WINDOW_OUT_REG_EN for an extra output stage (latency 3).
module window_generator_3x3
  import window_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_sof,
  input  logic [PIXEL_W-1:0] in_pixel,
  output logic [PIXEL_W-1:0] out_pixel_1,
  output logic [PIXEL_W-1:0] out_pixel_2,
  output logic [PIXEL_W-1:0] out_pixel_3,
  output logic [PIXEL_W-1:0] out_pixel_4,
  output logic [PIXEL_W-1:0] out_pixel_5,
  output logic [PIXEL_W-1:0] out_pixel_6,
  output logic [PIXEL_W-1:0] out_pixel_7,
  output logic [PIXEL_W-1:0] out_pixel_8,
  output logic [PIXEL_W-1:0] out_pixel_9,
  output logic               out_valid,
  output logic               frame_done
);

  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_col;
  logic [CW-1:0] w_pos_col;
  logic [CW-1:0] w_nxt_col;
  logic [RW-1:0] r_row;
  logic [RW-1:0] w_pos_row;
  logic [RW-1:0] w_nxt_row;
  logic          w_col_wrap;
  logic          w_row_wrap;
  logic          w_frame_wrap;
  logic          w_win_ok;

  // in_sof forces the current pixel to (0,0) whatever the counters say
  always_comb begin
    w_pos_col    = in_sof ? '0 : r_col;
    w_pos_row    = in_sof ? '0 : r_row;
    w_col_wrap   = (w_pos_col == COL_LAST);
    w_row_wrap   = (w_pos_row == ROW_LAST);
    w_frame_wrap = w_col_wrap && w_row_wrap;
    w_nxt_col    = w_col_wrap ? '0 : w_pos_col + CW'(1);
    w_nxt_row    = w_pos_row;
    if (w_col_wrap) begin
      w_nxt_row = w_row_wrap ? '0 : w_pos_row + RW'(1);
    end
    w_win_ok = (r_state == STREAM)
            && (w_pos_row >= ROW_TWO)
            && (w_pos_col >= COL_TWO);
  end

  always_comb begin
    w_state_nxt = r_state;
    if (in_valid) begin
      unique case (r_state)
        IDLE:    w_state_nxt = FILL;
        FILL:    if (w_nxt_row == ROW_TWO) w_state_nxt = STREAM;
        STREAM:  if (w_frame_wrap || in_sof) w_state_nxt = FILL;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (in_valid) begin
        r_col <= w_nxt_col;
        r_row <= w_nxt_row;
      end
    end
  end

  pixel_t        w_lb1_rd;
  pixel_t        w_lb2_rd;
  logic          r_s1_valid;
  logic          r_s1_win;
  logic          r_s1_last;
  pixel_t        r_s1_pix;
  logic [CW-1:0] r_s1_col;

  line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIXEL_W)
  ) u_lb1 (
    .clk     (clk),
    .i_we    (in_valid),
    .i_waddr (w_pos_col),
    .i_wdata (in_pixel),
    .i_re    (in_valid),
    .i_raddr (w_pos_col),
    .o_rdata (w_lb1_rd)
  );

  // Older line is fed from the younger one's read port a cycle later
  line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (PIXEL_W)
  ) u_lb2 (
    .clk     (clk),
    .i_we    (r_s1_valid),
    .i_waddr (r_s1_col),
    .i_wdata (w_lb1_rd),
    .i_re    (in_valid),
    .i_raddr (w_pos_col),
    .o_rdata (w_lb2_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_win   <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_pix   <= '0;
      r_s1_col   <= '0;
    end else begin
      r_s1_valid <= in_valid;
      r_s1_win   <= in_valid && w_win_ok;
      r_s1_last  <= in_valid && w_frame_wrap;
      if (in_valid) begin
        r_s1_pix <= in_pixel;
        r_s1_col <= w_pos_col;
      end
    end
  end

  wcol_t w_new;
  wcol_t r_c0;
  wcol_t r_c1;
  wcol_t r_w0;
  wcol_t r_w1;
  wcol_t r_w2;
  logic  r_vld;
  logic  r_done;

  always_comb begin
    w_new     = '0;
    w_new.top = w_lb2_rd;
    w_new.mid = w_lb1_rd;
    w_new.bot = r_s1_pix;
  end

  // Shift history every accepted pixel; publish only complete windows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c0   <= '0;
      r_c1   <= '0;
      r_w0   <= '0;
      r_w1   <= '0;
      r_w2   <= '0;
      r_vld  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_vld  <= r_s1_valid && r_s1_win;
      r_done <= r_s1_valid && r_s1_last;
      if (r_s1_valid) begin
        r_c0 <= r_c1;
        r_c1 <= w_new;
        if (r_s1_win) begin
          r_w0 <= r_c0;
          r_w1 <= r_c1;
          r_w2 <= w_new;
        end
      end
    end
  end

  wcol_t w_o0;
  wcol_t w_o1;
  wcol_t w_o2;
  logic  w_o_vld;
  logic  w_o_done;

`ifdef WINDOW_OUT_REG_EN
  wcol_t r_o0;
  wcol_t r_o1;
  wcol_t r_o2;
  logic  r_o_vld;
  logic  r_o_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_o0     <= '0;
      r_o1     <= '0;
      r_o2     <= '0;
      r_o_vld  <= 1'b0;
      r_o_done <= 1'b0;
    end else begin
      r_o0     <= r_w0;
      r_o1     <= r_w1;
      r_o2     <= r_w2;
      r_o_vld  <= r_vld;
      r_o_done <= r_done;
    end
  end

  assign w_o0     = r_o0;
  assign w_o1     = r_o1;
  assign w_o2     = r_o2;
  assign w_o_vld  = r_o_vld;
  assign w_o_done = r_o_done;
`else
  assign w_o0     = r_w0;
  assign w_o1     = r_w1;
  assign w_o2     = r_w2;
  assign w_o_vld  = r_vld;
  assign w_o_done = r_done;
`endif

  assign out_pixel_1 = w_o0.top;
  assign out_pixel_2 = w_o1.top;
  assign out_pixel_3 = w_o2.top;
  assign out_pixel_4 = w_o0.mid;
  assign out_pixel_5 = w_o1.mid;
  assign out_pixel_6 = w_o2.mid;
  assign out_pixel_7 = w_o0.bot;
  assign out_pixel_8 = w_o1.bot;
  assign out_pixel_9 = w_o2.bot;
  assign out_valid   = w_o_vld;
  assign frame_done  = w_o_done;

endmodule

// File: tb/tb_window_generator_3x3.sv
// Randomised and directed bench for window_generator_3x3 (4x4 image).
// Expected windows come from a frame-image model in the bench.
module tb_window_generator_3x3;

  localparam int W = 4;
  localparam int H = 4;
`ifdef WINDOW_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [23:0] in_pixel = '0;
  logic [23:0] op1, op2, op3, op4, op5, op6, op7, op8, op9;
  logic        out_valid;
  logic        frame_done;

  window_generator_3x3 #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_sof      (in_sof),
    .in_pixel    (in_pixel),
    .out_pixel_1 (op1),
    .out_pixel_2 (op2),
    .out_pixel_3 (op3),
    .out_pixel_4 (op4),
    .out_pixel_5 (op5),
    .out_pixel_6 (op6),
    .out_pixel_7 (op7),
    .out_pixel_8 (op8),
    .out_pixel_9 (op9),
    .out_valid   (out_valid),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               due;
    logic [8:0][23:0] p;
    logic             done;
  } exp_t;

  typedef struct {
    int          due;
    logic [23:0] p1;
    logic [23:0] p5;
    logic [23:0] p9;
    logic        done;
  } lit_t;

  exp_t             q[$];
  lit_t             lq[$];
  logic [8:0][23:0] held = '0;
  logic [23:0]      img[H][W];
  int               mr = 0;
  int               mc = 0;
  int               ncmp = 0;
  int               nerr = 0;
  int               nwin = 0;
  int               ndone = 0;

  function automatic logic [23:0] pat(input int r, input int c);
    logic [7:0] b;
    b = 8'(r * 16 + c);
    return {b, b, b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Frame-image model: a window exists for every pixel at row>=2, col>=2
  task automatic model_accept(input logic sof, input logic [23:0] p,
                              input int acc);
    exp_t e;
    if (sof) begin
      mr = 0;
      mc = 0;
    end
    img[mr][mc] = p;
    if (mr >= 2 && mc >= 2) begin
      e.due = acc + LAT;
      for (int k = 0; k < 9; k++) e.p[k] = img[mr-2+k/3][mc-2+k%3];
      e.done = (mr == H - 1) && (mc == W - 1);
      q.push_back(e);
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      mr++;
      if (mr == H) mr = 0;
    end
  endtask

  task automatic drive(input logic sof, input logic [23:0] p);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_sof   = sof;
    in_pixel = p;
    model_accept(sof, p, cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'($urandom);
      in_pixel = 24'($urandom);
    end
  endtask

  task automatic add_lit(input logic [23:0] p1, input logic [23:0] p5,
                         input logic [23:0] p9, input logic done);
    lit_t l;
    l.due  = cyc + LAT;
    l.p1   = p1;
    l.p5   = p5;
    l.p9   = p9;
    l.done = done;
    lq.push_back(l);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    q.delete();
    lq.delete();
    held = '0;
    mr   = 0;
    mc   = 0;
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_p1", {8'd0, op1}, 32'd0);
    chk("rst_p5", {8'd0, op5}, 32'd0);
    chk("rst_p9", {8'd0, op9}, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic std_frame(input logic sof_first, input bit gaps);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        drive(sof_first && r == 0 && c == 0, pat(r, c));
        if (r == 2 && c == 2)
          add_lit(24'h000000, 24'h111111, 24'h222222, 1'b0);
        if (r == 3 && c == 3)
          add_lit(24'h111111, 24'h222222, 24'h333333, 1'b1);
        if (gaps) idle(1);
      end
    end
  endtask

  always @(negedge clk) begin
    logic             ev;
    logic             ed;
    logic [8:0][23:0] dw;
    lit_t             l;
    dw = {op9, op8, op7, op6, op5, op4, op3, op2, op1};
    ev = 1'b0;
    ed = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      ev   = 1'b1;
      ed   = q[0].done;
      held = q[0].p;
      void'(q.pop_front());
    end
    ncmp++;
    if (out_valid !== ev || frame_done !== ed || dw !== held) begin
      nerr++;
      $display("FAIL window cyc=%0d valid=%b want %b done=%b want %b p1=%h want %h p5=%h want %h p9=%h want %h",
               cyc, out_valid, ev, frame_done, ed, op1, held[0],
               op5, held[4], op9, held[8]);
    end
    if (out_valid === 1'b1) nwin++;
    if (frame_done === 1'b1) ndone++;
    if (lq.size() > 0 && lq[0].due == cyc) begin
      l = lq.pop_front();
      ncmp++;
      if (out_valid !== 1'b1 || frame_done !== l.done || op1 !== l.p1 ||
          op5 !== l.p5 || op9 !== l.p9) begin
        nerr++;
        $display("FAIL literal cyc=%0d valid=%b done=%b want %b p1=%h want %h p5=%h want %h p9=%h want %h",
                 cyc, out_valid, frame_done, l.done, op1, l.p1,
                 op5, l.p5, op9, l.p9);
      end
    end
  end

  initial begin
    int w0;
    int d0;
    repeat (3) @(posedge clk);
    #2;
    chk("init_valid", {31'd0, out_valid}, 32'd0);
    chk("init_done", {31'd0, frame_done}, 32'd0);
    chk("init_p5", {8'd0, op5}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // contiguous frame
    w0 = nwin;
    d0 = ndone;
    std_frame(1'b1, 1'b0);
    idle(LAT + 2);
    chk("contig_windows", 32'(nwin - w0), 32'd4);
    chk("contig_done", 32'(ndone - d0), 32'd1);

    // in_valid every other cycle
    w0 = nwin;
    std_frame(1'b0, 1'b1);
    idle(LAT + 2);
    chk("gapped_windows", 32'(nwin - w0), 32'd4);

    // in_sof arriving at (1,3) aborts the frame
    w0 = nwin;
    for (int i = 0; i < W + 3; i++)
      drive(1'b0, pat(i / W, i % W) ^ 24'hA5A5A5);
    std_frame(1'b1, 1'b0);
    idle(LAT + 2);
    chk("sof_windows", 32'(nwin - w0), 32'd4);

    // reset in row 2 while a window is on the outputs
    for (int i = 0; i < 2 * W + 4; i++)
      drive(1'b0, pat(i / W, i % W) ^ 24'h5A5A5A);
    idle(1);
    do_reset();
    w0 = nwin;
    std_frame(1'b0, 1'b0);
    idle(LAT + 2);
    chk("postrst_windows", 32'(nwin - w0), 32'd4);

    // back-to-back frames
    w0 = nwin;
    d0 = ndone;
    std_frame(1'b1, 1'b0);
    std_frame(1'b0, 1'b0);
    idle(LAT + 2);
    chk("b2b_windows", 32'(nwin - w0), 32'd8);
    chk("b2b_done", 32'(ndone - d0), 32'd2);

    // random pixels, gaps and occasional in_sof / reset
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < W * H; i++) begin
        drive($urandom_range(0, 31) == 0, 24'($urandom));
        idle($urandom_range(0, 2));
        if (f == 5 && i == 9) do_reset();
      end
    end
    idle(LAT + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
